// File: rtl/sfm_streamer_word_packer_if.sv
// sfm_streamer_word_packer_if: element-beat input stream and packed-word output stream bundle
//   in_*  : producer -> packer beats (valid/ready, IN_N lanes of EW bits, lane count, last)
//   out_* : packer -> store streamer words (valid/ready, DW data, DW/8 strobe, last)
//   done  : packer -> consumer, one-cycle end-of-vector pulse
interface sfm_streamer_word_packer_if #(
  parameter int DW   = 256,
  parameter int EW   = 16,
  parameter int IN_N = 4
);
  localparam int CW = $clog2(IN_N) + 1;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_N*EW-1:0]   in_data;
  logic [CW-1:0]        in_cnt;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [DW/8-1:0]      out_strb;
  logic                 out_last;
  logic                 done;
  modport master (
    output in_valid, in_data, in_cnt, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_strb, out_last, done
  );
  modport slave (
    input  in_valid, in_data, in_cnt, in_last, out_ready,
    output in_ready, out_valid, out_data, out_strb, out_last, done
  );
endinterface

// File: rtl/sfm_streamer_word_packer.sv
// sfm_streamer_word_packer: packs IN_N-element beats into DW-bit words with lane-accurate byte strobes
//   clk_i, rst_i (sync, active-high), clear_i (sync soft clear, same effect as rst_i)
//   s           : slave side of sfm_streamer_word_packer_if (input beats, output words, done pulse)
//   stall_cnt_o : saturating count of stalled output cycles, present only with SFM_PACKER_PERF_CNT_EN
module sfm_streamer_word_packer #(
  parameter int DW   = 256,
  parameter int EW   = 16,
  parameter int IN_N = 4
) (
  input logic clk_i,
  input logic rst_i,
  input logic clear_i,
  sfm_streamer_word_packer_if.slave s
`ifdef SFM_PACKER_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);
  localparam int WN = DW / EW;
  localparam int FW = $clog2(WN);
  localparam int NW = FW + 1;
  localparam int CW = $clog2(IN_N) + 1;
  localparam int BL = EW / 8;
  logic [FW-1:0]      fill_q, fill_d;
  logic [DW-1:0]      pack_q, pack_d, data_q, data_d, merged;
  logic [DW/8-1:0]    strb_q, strb_d, strb_new;
  logic               valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic [IN_N*EW-1:0] beat;
  logic [NW-1:0]      nf;
  logic               acc, hs, cmp, emit;
  assign s.in_ready  = !valid_q | s.out_ready;
  assign s.out_valid = valid_q;
  assign s.out_data  = data_q;
  assign s.out_strb  = strb_q;
  assign s.out_last  = last_q;
  assign s.done      = done_q;
  assign acc = s.in_valid & s.in_ready;
  assign hs  = valid_q & s.out_ready;
  assign nf  = NW'(fill_q) + NW'(s.in_cnt);
  // word closes on a full fill or end of vector; an empty closing beat with nothing packed emits no word
  assign cmp  = acc & ((nf >= NW'(WN)) | s.in_last);
  assign emit = cmp & (nf != '0);
  // lanes beyond in_cnt are zeroed so the OR-merge keeps unfilled lanes of the word at zero
  assign merged = pack_q | (DW'(beat) << (fill_q * EW));
  always_comb begin
    beat     = '0;
    strb_new = '0;
    for (int i = 0; i < IN_N; i++) beat[i*EW +: EW] = CW'(i) < s.in_cnt ? s.in_data[i*EW +: EW] : '0;
    for (int i = 0; i < WN; i++) strb_new[i*BL +: BL] = NW'(i) < nf ? '1 : '0;
  end
  always_comb begin
    fill_d  = cmp ? '0 : acc ? nf[FW-1:0] : fill_q;
    pack_d  = cmp ? '0 : acc ? merged : pack_q;
    data_d  = emit ? merged : hs ? '0 : data_q;
    strb_d  = emit ? strb_new : hs ? '0 : strb_q;
    last_d  = emit ? s.in_last : hs ? 1'b0 : last_q;
    valid_d = emit | (valid_q & !s.out_ready);
    done_d  = (hs & last_q) | (acc & s.in_last & (nf == '0));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      fill_q  <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
`ifdef SFM_PACKER_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = (valid_q & !s.out_ready & ~&stall_q) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt_o = stall_q;
`endif
  // short beats are only legal as the closing beat of a vector
  a_short_beat: assert property (@(posedge clk_i) disable iff (rst_i | clear_i)
    (acc && !s.in_last) |-> (s.in_cnt == CW'(IN_N)));
endmodule

// File: tb/tb_sfm_streamer_word_packer.sv
// tb_sfm_streamer_word_packer: directed and randomized checks of the word packer against an element-level model
module tb_sfm_streamer_word_packer;
  localparam int DW = 256, EW = 16, IN_N = 4, WN = 16;
  typedef struct {logic [DW-1:0] d; logic [31:0] s; logic l; int c;} wrd_t;
  logic clk = 0, rst = 1, clear = 0;
  int total = 0, bad = 0, cyc = 0, rmode = 0, exp_done = 0;
  logic [EW-1:0] vec[$];
  wrd_t exp_w[$], got[$];
  int done_c[$];
  sfm_streamer_word_packer_if #(.DW(DW), .EW(EW), .IN_N(IN_N)) bus ();
`ifdef SFM_PACKER_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif
  sfm_streamer_word_packer #(.DW(DW), .EW(EW), .IN_N(IN_N)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clear_i(clear),
    .s(bus)
`ifdef SFM_PACKER_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && !clear) begin
      if (bus.out_valid && bus.out_ready) got.push_back('{bus.out_data, bus.out_strb, bus.out_last, cyc + 1});
      if (bus.done) done_c.push_back(cyc);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic set_rdy();
    bus.out_ready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : ($urandom % 4 != 0);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input int cnt, input bit last);
    logic [IN_N*EW-1:0] d;
    logic acc;
    int n;
    n = 0;
    acc = 0;
    d = {$urandom, $urandom};
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_cnt = 3'(cnt);
    bus.in_last = last;
    for (int j = 0; j < cnt; j++) vec.push_back(d[j*EW +: EW]);
    while (!acc && n < 200) begin
      set_rdy();
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_accepted", acc, 1);
    bus.in_valid = 0;
    bus.in_last = 0;
  endtask
  task automatic finish_vec(input int lc);
    int n, nw, k;
    wrd_t x;
    n = vec.size();
    nw = (n + WN - 1) / WN;
    for (int w = 0; w < nw; w++) begin
      k = (n - w * WN < WN) ? n - w * WN : WN;
      x.d = '0;
      for (int j = 0; j < k; j++) x.d[j*EW +: EW] = vec[w*WN+j];
      x.s = (k == WN) ? 32'hFFFF_FFFF : 32'((64'd1 << (2 * k)) - 64'd1);
      x.l = (w == nw - 1) && !(lc == 0 && n % WN == 0);
      x.c = 0;
      exp_w.push_back(x);
    end
    exp_done++;
    vec.delete();
  endtask
  task automatic send_vec(input int nfull, input int lc);
    for (int i = 0; i < nfull; i++) send_beat(IN_N, 0);
    send_beat(lc, 1);
    finish_vec(lc);
  endtask
  task automatic pulse_clear();
    clear = 1;
    step();
    clear = 0;
  endtask
  task automatic drain_check(input string tag);
    int n, m;
    bit found;
    n = 0;
    bus.in_valid = 0;
    while (got.size() < exp_w.size() && n < 500) begin
      set_rdy();
      step();
      n++;
    end
    bus.out_ready = 1;
    repeat (3) step();
    chk({tag, "_word_count"}, got.size(), exp_w.size());
    chk({tag, "_done_count"}, done_c.size(), exp_done);
    m = got.size() < exp_w.size() ? got.size() : exp_w.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_data"}, got[i].d, exp_w[i].d);
      chk({tag, "_strb"}, got[i].s, exp_w[i].s);
      chk({tag, "_last"}, got[i].l, exp_w[i].l);
      if (exp_w[i].l) begin
        found = 0;
        foreach (done_c[j]) if (done_c[j] == got[i].c) found = 1;
        chk({tag, "_done_after_last_hs"}, found, 1);
      end
    end
    got.delete();
    exp_w.delete();
    done_c.delete();
    exp_done = 0;
  endtask
  initial begin
    logic [DW-1:0] hd;
    logic [31:0] hs;
    logic hl;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_cnt = '0;
    bus.in_last = 0;
    bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_strb", bus.out_strb, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rmode = 0;
    for (int i = 0; i < 3; i++) send_beat(IN_N, 0);
    chk("t1_no_valid_early", bus.out_valid, 0);
    send_beat(IN_N, 1);
    finish_vec(IN_N);
    chk("t1_valid_after_accept", bus.out_valid, 1);
    chk("t1_strb", bus.out_strb, 32'hFFFF_FFFF);
    chk("t1_last", bus.out_last, 1);
    drain_check("t1");
    send_beat(IN_N, 0);
    send_beat(IN_N, 0);
    send_beat(2, 1);
    finish_vec(2);
    chk("t2_strb", bus.out_strb, 32'h000F_FFFF);
    drain_check("t2");
    send_vec(8, 4);
    drain_check("t3");
    pulse_clear();
    rmode = 2;
    send_vec(3, 4);
    hd = bus.out_data;
    hs = bus.out_strb;
    hl = bus.out_last;
    chk("t4_valid", bus.out_valid, 1);
    bus.in_valid = 1;
    bus.in_cnt = 3'(IN_N);
    bus.in_data = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      chk("t4_in_ready_low", bus.in_ready, 0);
      chk("t4_data_stable", bus.out_data, hd);
      chk("t4_strb_stable", bus.out_strb, hs);
      chk("t4_last_stable", bus.out_last, hl);
      step();
    end
`ifdef SFM_PACKER_PERF_CNT_EN
    chk("t4_stall_cnt", stall_cnt, 10);
`endif
    bus.in_valid = 0;
    rmode = 0;
    drain_check("t4");
    send_vec(0, 0);
    chk("t5a_done", bus.done, 1);
    chk("t5a_no_valid", bus.out_valid, 0);
    step();
    chk("t5a_done_one_cycle", bus.done, 0);
    drain_check("t5a");
    send_vec(2, 0);
    chk("t5b_valid", bus.out_valid, 1);
    chk("t5b_strb", bus.out_strb, 32'h0000_FFFF);
    chk("t5b_last", bus.out_last, 1);
    drain_check("t5b");
    send_beat(IN_N, 0);
    send_beat(IN_N, 0);
    pulse_clear();
    vec.delete();
    chk("t6_valid_after_clear", bus.out_valid, 0);
    send_vec(3, 4);
    drain_check("t6");
    rmode = 1;
    for (int v = 0; v < 25; v++) begin
      int nf, lc;
      nf = $urandom_range(0, 10);
      lc = nf == 0 ? $urandom_range(1, 4) : $urandom_range(0, 4);
      send_vec(nf, lc);
    end
    drain_check("rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
